uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_bit_timer.sv | 37 +++
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, receiver FSM states and bit-period math.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_e;
`else
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_e;
`endif

   // Truncating division; shared with uart_tx so both ends agree on the bit period.
   function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter: expire_o pulses on the last enabled cycle of a loaded
// period, so a reload on expiry yields an exact period of load_val_i cycles.
module uart_bit_timer #(
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             expire_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   // NOTE: every signal written here gets a default first, so no path infers a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign expire_o = en_i && (cnt_q == WIDTH'(1));

   // NOTE: state registers use non-blocking assignment so all flops see pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default; defining UART_RX_PARITY_EN adds one even-parity
// bit after the data bits. Bytes are held on data/valid until handshaken.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err
);

   localparam int unsigned CPB  = clks_per_bit(CLK_FREQ, BAUD);
   localparam int unsigned HALF = CPB / 2;
   localparam int unsigned TW   = $clog2(CPB + 1);
   localparam int unsigned BCW  = $clog2(DATA_BITS);

   localparam logic [TW-1:0]  CPB_T    = TW'(CPB);
   localparam logic [TW-1:0]  HALF_T   = TW'(HALF);
   localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

   rx_state_e            state_q, state_d;
   logic                 rxd_meta_q, rxd_sync_q;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, overrun_q, overrun_d;

   logic                 tmr_load, tmr_en, tmr_expire;
   logic [TW-1:0]        tmr_val;
   logic                 deliver, stop_bad;

`ifdef UART_RX_PARITY_EN
   logic                 par_bad_q, par_bad_d;
   logic                 parity_err_q, parity_err_d;
`endif

   uart_bit_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .en_i      (tmr_en),
      .expire_o  (tmr_expire)
   );

   assign tmr_en = (state_q != IDLE) && (state_q != WAIT_IDLE);

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tmr_load  = 1'b0;
      tmr_val   = CPB_T;
      deliver   = 1'b0;
      stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
`endif
      case (state_q)
         IDLE: begin
            if (!rxd_sync_q) begin
               tmr_load = 1'b1;
               tmr_val  = HALF_T;
               state_d  = START;
            end
         end
         START: begin
            // A start bit that is high again at mid-bit was a glitch.
            if (tmr_expire) begin
               if (!rxd_sync_q) begin
                  tmr_load  = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = DATA;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (tmr_expire) begin
               shift_d  = {rxd_sync_q, shift_q[DATA_BITS-1:1]};
               tmr_load = 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tmr_expire) begin
               par_bad_d = rxd_sync_q != (^shift_q);
               tmr_load  = 1'b1;
               state_d   = STOP;
            end
         end
`endif
         STOP: begin
            if (tmr_expire) begin
               if (rxd_sync_q) begin
                  deliver = 1'b1;
                  state_d = IDLE;
               end else begin
                  stop_bad = 1'b1;
                  state_d  = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            if (rxd_sync_q) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A delivery always sets valid; a handshake only clears it when nothing new arrives.
   always_comb begin
      valid_d   = deliver || (valid_q && !ready);
      data_d    = deliver ? shift_q : data_q;
      overrun_d = deliver && valid_q && !ready;
`ifdef UART_RX_PARITY_EN
      parity_err_d = deliver && par_bad_q;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rxd_meta_q  <= 1'b1;
         rxd_sync_q  <= 1'b1;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rxd_meta_q  <= rxd;
         rxd_sync_q  <= rxd_meta_q;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= stop_bad;
         overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
         par_bad_q    <= par_bad_d;
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 100 MHz / 115200 baud: serial frames are driven bit by bit,
// expected bytes are queued at send time and matched by a delivery monitor.
module tb_uart_rx;

   localparam int CPB = 868;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b1;
   logic       rxd     = 1'b1;
   logic       ready   = 1'b1;
   logic [7:0] data;
   logic       valid, frame_err, overrun, parity_err;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb[$];
   int valid_rise_cnt = 0;
   int frame_err_cnt  = 0;
   int overrun_cnt    = 0;
   int parity_err_cnt = 0;
   int run_len        = 0;
   int max_run        = 0;

   always #5 clk = ~clk;

   uart_rx #(
      .CLK_FREQ(100000000),
      .BAUD    (115200)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rxd       (rxd),
      .data      (data),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .parity_err(parity_err)
   );

   // Delivery monitor: a new byte shows as a valid rise, an overrun pulse, or valid
   // staying high right after a handshake cycle.
   initial begin
      logic       prev_valid;
      logic       prev_ready;
      logic [7:0] exp;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            run_len    = 0;
         end else begin
            if (frame_err)  frame_err_cnt++;
            if (overrun)    overrun_cnt++;
            if (parity_err) parity_err_cnt++;
            if (valid && !prev_valid) valid_rise_cnt++;
            if ((valid && !prev_valid) || overrun || (valid && prev_valid && prev_ready)) begin
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL delivery: unexpected byte got=%02h required=none", data);
               end else begin
                  exp = sb.pop_front();
                  if (data !== exp) begin
                     bad++;
                     $display("FAIL delivery: data got=%02h required=%02h", data, exp);
                  end
               end
            end
            run_len = valid ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            prev_valid = valid;
            prev_ready = ready;
         end
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
      rxd = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         wait_cycles(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rxd = (^b) ^ par_flip;
      wait_cycles(CPB);
`endif
      rxd = stop_bit;
      wait_cycles(CPB);
      rxd = 1'b1;
      wait_cycles(4);
   endtask

   task automatic test_reset();
      #1;
      reset_n = 1'b0;
      #1;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b required=0", valid); end
      total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got=%02h required=00", data); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got=%b required=0", frame_err); end
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got=%b required=0", overrun); end
      total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity_err: got=%b required=0", parity_err); end
      wait_cycles(3);
      reset_n = 1'b1;
      wait_cycles(10);
   endtask

   task automatic test_single();
      int rises, ferr, ovr, perr;
      rises = valid_rise_cnt; ferr = frame_err_cnt; ovr = overrun_cnt; perr = parity_err_cnt;
      ready   = 1'b1;
      max_run = 0;
      sb.push_back(8'h55);
      send_frame(8'h55, 1'b1, 1'b0);
      wait_cycles(2);
      total++; if (valid_rise_cnt - rises !== 1) begin bad++; $display("FAIL single_rises: got=%0d required=1", valid_rise_cnt - rises); end
      total++; if (max_run !== 1) begin bad++; $display("FAIL single_valid_len: got=%0d required=1", max_run); end
      total++; if (data !== 8'h55) begin bad++; $display("FAIL single_data: got=%02h required=55", data); end
      total++; if ((frame_err_cnt - ferr) + (overrun_cnt - ovr) + (parity_err_cnt - perr) !== 0) begin
         bad++; $display("FAIL single_err_pulses: got=%0d required=0",
                         (frame_err_cnt - ferr) + (overrun_cnt - ovr) + (parity_err_cnt - perr));
      end
   endtask

   task automatic test_back_to_back_overrun();
      int rises, ovr;
      rises = valid_rise_cnt; ovr = overrun_cnt;
      ready = 1'b0;
      sb.push_back(8'hA3);
      send_frame(8'hA3, 1'b1, 1'b0);
      sb.push_back(8'h3C);
      send_frame(8'h3C, 1'b1, 1'b0);
      total++; if (overrun_cnt - ovr !== 1) begin bad++; $display("FAIL overrun_count: got=%0d required=1", overrun_cnt - ovr); end
      total++; if (data !== 8'h3C) begin bad++; $display("FAIL overrun_data: got=%02h required=3c", data); end
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL overrun_valid: got=%b required=1", valid); end
      total++; if (valid_rise_cnt - rises !== 1) begin bad++; $display("FAIL overrun_rises: got=%0d required=1", valid_rise_cnt - rises); end
      ready = 1'b1;
      wait_cycles(2);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL overrun_drain: valid got=%b required=0", valid); end
      total++; if (data !== 8'h3C) begin bad++; $display("FAIL overrun_hold: data got=%02h required=3c", data); end
   endtask

   task automatic test_glitch();
      int rises, ferr, ovr;
      rises = valid_rise_cnt; ferr = frame_err_cnt; ovr = overrun_cnt;
      rxd = 1'b0;
      wait_cycles(300);
      rxd = 1'b1;
      wait_cycles(2 * CPB);
      total++; if (valid_rise_cnt - rises !== 0) begin bad++; $display("FAIL glitch_valid: got=%0d required=0", valid_rise_cnt - rises); end
      total++; if ((frame_err_cnt - ferr) + (overrun_cnt - ovr) !== 0) begin
         bad++; $display("FAIL glitch_err_pulses: got=%0d required=0", (frame_err_cnt - ferr) + (overrun_cnt - ovr));
      end
   endtask

   task automatic test_frame_err();
      int rises, ferr;
      rises = valid_rise_cnt; ferr = frame_err_cnt;
      ready = 1'b1;
      send_frame(8'hFF, 1'b0, 1'b0);
      wait_cycles(CPB);
      total++; if (frame_err_cnt - ferr !== 1) begin bad++; $display("FAIL frame_err_count: got=%0d required=1", frame_err_cnt - ferr); end
      total++; if (valid_rise_cnt - rises !== 0) begin bad++; $display("FAIL frame_err_valid: got=%0d required=0", valid_rise_cnt - rises); end
      ready = 1'b0;
      sb.push_back(8'h12);
      send_frame(8'h12, 1'b1, 1'b0);
      total++; if (data !== 8'h12) begin bad++; $display("FAIL frame_err_next: data got=%02h required=12", data); end
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL frame_err_next: valid got=%b required=1", valid); end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      b   = 8'hB4;
      rxd = 1'b0;
      wait_cycles(CPB);
      for (int i = 0; i < 4; i++) begin
         rxd = b[i];
         wait_cycles(CPB);
      end
      rxd = b[4];
      wait_cycles(CPB / 2);
      reset_n = 1'b0;
      #1;
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL midreset_valid: got=%b required=0", valid); end
      total++; if (data !== 8'h00) begin bad++; $display("FAIL midreset_data: got=%02h required=00", data); end
      rxd   = 1'b1;
      ready = 1'b1;
      wait_cycles(5);
      reset_n = 1'b1;
      wait_cycles(CPB);
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL midreset_idle: valid got=%b required=0", valid); end
      sb.push_back(8'h81);
      send_frame(8'h81, 1'b1, 1'b0);
      total++; if (data !== 8'h81) begin bad++; $display("FAIL midreset_next: data got=%02h required=81", data); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int perr, ferr;
      perr = parity_err_cnt; ferr = frame_err_cnt;
      ready = 1'b1;
      sb.push_back(8'h07);
      send_frame(8'h07, 1'b1, 1'b1);
      total++; if (parity_err_cnt - perr !== 1) begin bad++; $display("FAIL parity_count: got=%0d required=1", parity_err_cnt - perr); end
      total++; if (frame_err_cnt - ferr !== 0) begin bad++; $display("FAIL parity_frame_err: got=%0d required=0", frame_err_cnt - ferr); end
      total++; if (data !== 8'h07) begin bad++; $display("FAIL parity_data: got=%02h required=07", data); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back_overrun();
      test_glitch();
      test_frame_err();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`else
      total++; if (parity_err_cnt !== 0) begin bad++; $display("FAIL parity_tied: pulses got=%0d required=0", parity_err_cnt); end
`endif
      wait_cycles(4);
      total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard: undelivered got=%0d required=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
